vend_sequencer: RTL and testbench
=================================

# vend_sequencer

Next-state sequencer for the vending-machine controller. Samples selection, coin and cancel pulses, accumulates credit against a fixed price, and times the dispense and change-return phases. Drives the 3-bit `fsm_state` bus consumed by the vending output decoder, which turns that bus into the `dispense` and `give_change` strobes. Also reports the current credit and the change amount owed.

## Interface
- `PRICE`, 75: item price in cents. Legal range 1..230, so credit never exceeds 8 bits.
- `PULSE_CYCLES`, 4: number of cycles spent in DISPENSING, and separately in CHANGERETURN. Must be at least 1.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in WAITPAYMENT before an automatic cancel. Must be at least 2.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `select`  in  1  one-cycle item-selection pulse.
- `coin_quarter`  in  1  one-cycle pulse, 25 cents inserted.
- `coin_dime`  in  1  one-cycle pulse, 10 cents inserted.
- `cancel`  in  1  one-cycle pulse, customer abort.
- `fsm_state`  out  3  current state encoding (see Operation).
- `credit`  out  8  accumulated cents for the current transaction.
- `change_amt`  out  8  cents to return. Nonzero only in CHANGERETURN.
- `busy`  out  1  high whenever `fsm_state` is not WAITSELECTION.

## Operation
- State encoding: WAITSELECTION=0, WAITPAYMENT=1, GOTQUARTER=2, GOTDIME=3, DISPENSING=4, CHANGERETURN=5. Codes 6 and 7 are unreachable; if ever decoded they go to WAITSELECTION next cycle with `credit` cleared.
- WAITSELECTION
  - `select` goes to WAITPAYMENT with `credit` set to 0.
  - Coins and `cancel` are ignored.
- WAITPAYMENT, priority order:
  - `coin_quarter` goes to GOTQUARTER and adds 25 to `credit`.
  - Otherwise `coin_dime` goes to GOTDIME and adds 10 to `credit`.
  - Otherwise `cancel`, or the timeout counter reaching `TIMEOUT_CYCLES`, triggers an abort:
    - if `credit` > 0: go to CHANGERETURN with `change_amt` = `credit`;
    - else: go to WAITSELECTION.
  - A simultaneous quarter and dime accepts only the quarter.
  - A coin arriving in the same cycle as `cancel` wins; that `cancel` is dropped.
  - `select` is ignored.
- Timeout counter
  - Cleared on entry to WAITPAYMENT and on any accepted coin.
  - Increments once per cycle while in WAITPAYMENT with no coin present.
- GOTQUARTER / GOTDIME
  - Each lasts exactly one cycle and is visible with the updated `credit`.
  - Next state: DISPENSING if `credit` >= `PRICE`, else WAITPAYMENT.
- DISPENSING
  - Lasts exactly `PULSE_CYCLES` cycles; all inputs ignored.
  - Exit: if `credit` > `PRICE`, go to CHANGERETURN with `change_amt` = `credit` - `PRICE`.
  - Otherwise go to WAITSELECTION with `credit` cleared.
- CHANGERETURN
  - Lasts exactly `PULSE_CYCLES` cycles; all inputs ignored.
  - Then go to WAITSELECTION with `credit` and `change_amt` cleared.
- Arithmetic: 8-bit unsigned, no saturation needed; the `PRICE` limit guarantees `credit` <= 254.

## Timing
- Reset values: `fsm_state`=0, `credit`=0, `change_amt`=0, `busy`=0; pulse and timeout counters are 0.
- Reset is asynchronous. Asserting it mid-transaction, including during DISPENSING, returns all outputs to their reset values immediately; the credit is forfeited.
- All outputs are registered and change only on a `clk` rising edge or on reset.
- Latency:
  - Input pulse sampled at edge n; the new state is visible after edge n.
  - A coin that completes payment shows GOTQUARTER or GOTDIME for one cycle, then DISPENSING.
- Timeout: with no coin, the abort transition occurs on the `TIMEOUT_CYCLES`-th edge after entering WAITPAYMENT (or after the last accepted coin).
- `dispense` (from the downstream decoder) is high for exactly `PULSE_CYCLES` consecutive cycles per vend. `give_change` behaves the same per return.

## Test plan
- Exact pay (`PRICE`=75):
  - Stimulus: `select`, then three quarters spaced 3 cycles apart.
  - Required: `credit` 25, 50, 75; DISPENSING for 4 cycles; no CHANGERETURN; back to WAITSELECTION with `credit`=0.
- Overpay:
  - Stimulus: `select`, quarter, quarter, dime, dime, dime.
  - Required: `credit` 80; DISPENSING for 4 cycles; then CHANGERETURN for 4 cycles with `change_amt`=5; then idle.
- Cancel:
  - Stimulus: `select`, quarter, dime, then `cancel`.
  - Required: CHANGERETURN with `change_amt`=35, no DISPENSING.
  - Required: a separate `cancel` at `credit`=0 goes directly to WAITSELECTION.
- Timeout (`TIMEOUT_CYCLES`=8):
  - Stimulus: `select`, one dime, then no input.
  - Required: CHANGERETURN with `change_amt`=10 exactly 8 edges after the dime.
- Collisions:
  - Quarter and dime in the same cycle: `credit` rises by 25 only.
  - Coin and `cancel` in the same cycle: coin accepted, no abort.
  - Coins in WAITSELECTION: `credit` stays 0.
- Reset:
  - Stimulus: assert `rst_n`=0 during the 2nd DISPENSING cycle.
  - Required: all outputs 0 immediately; after release, the FSM idles until the next `select`.

Source files
------------

// File: rtl/vend_sequencer.sv
// Next-state sequencer for the vending-machine controller: tracks credit against a
// fixed price and times the dispense / change-return phases on the fsm_state bus.
module vend_sequencer #(
    parameter int unsigned PRICE          = 75,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       select,
    input  logic       coin_quarter,
    input  logic       coin_dime,
    input  logic       cancel,
    output logic [2:0] fsm_state,
    output logic [7:0] credit,
    output logic [7:0] change_amt,
    output logic       busy
);

    typedef enum logic [2:0] {
        WAITSELECTION = 3'd0,
        WAITPAYMENT   = 3'd1,
        GOTQUARTER    = 3'd2,
        GOTDIME       = 3'd3,
        DISPENSING    = 3'd4,
        CHANGERETURN  = 3'd5
    } state_t;

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    PRICE_C    = 8'(PRICE);

    state_t        r_state;
    logic [7:0]    r_credit;
    logic [7:0]    r_change;
    logic [PW-1:0] r_pulse;
    logic [TW-1:0] r_tmo;
    logic          r_busy;

    state_t        w_state_nx;
    logic [7:0]    w_credit_nx;
    logic [7:0]    w_change_nx;
    logic [PW-1:0] w_pulse_nx;
    logic [TW-1:0] w_tmo_nx;
    logic          w_tmo_hit;
    logic          w_pulse_done;

    assign w_tmo_hit    = (r_tmo == TMO_LAST);
    assign w_pulse_done = (r_pulse == PULSE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= WAITSELECTION;
            r_credit <= 8'd0;
            r_change <= 8'd0;
            r_pulse  <= '0;
            r_tmo    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_credit <= w_credit_nx;
            r_change <= w_change_nx;
            r_pulse  <= w_pulse_nx;
            r_tmo    <= w_tmo_nx;
            r_busy   <= (w_state_nx != WAITSELECTION);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_credit_nx = r_credit;
        w_change_nx = r_change;
        w_pulse_nx  = r_pulse;
        w_tmo_nx    = r_tmo;
        case (r_state)
            WAITSELECTION: begin
                if (select) begin
                    w_state_nx  = WAITPAYMENT;
                    w_credit_nx = 8'd0;
                    w_tmo_nx    = '0;
                end
            end
            WAITPAYMENT: begin
                if (coin_quarter) begin
                    w_state_nx  = GOTQUARTER;
                    w_credit_nx = r_credit + 8'd25;
                    w_tmo_nx    = '0;
                end else if (coin_dime) begin
                    w_state_nx  = GOTDIME;
                    w_credit_nx = r_credit + 8'd10;
                    w_tmo_nx    = '0;
                end else if (cancel || w_tmo_hit) begin
                    w_tmo_nx = '0;
                    if (r_credit != 8'd0) begin
                        w_state_nx  = CHANGERETURN;
                        w_change_nx = r_credit;
                        w_pulse_nx  = '0;
                    end else begin
                        w_state_nx = WAITSELECTION;
                    end
                end else begin
                    w_tmo_nx = r_tmo + TW'(1);
                end
            end
            GOTQUARTER, GOTDIME: begin
                // The timeout is measured from the coin edge, so this cycle counts too.
                w_tmo_nx = r_tmo + TW'(1);
                if (r_credit >= PRICE_C) begin
                    w_state_nx = DISPENSING;
                    w_pulse_nx = '0;
                end else begin
                    w_state_nx = WAITPAYMENT;
                end
            end
            DISPENSING: begin
                if (w_pulse_done) begin
                    w_pulse_nx = '0;
                    if (r_credit > PRICE_C) begin
                        w_state_nx  = CHANGERETURN;
                        w_change_nx = r_credit - PRICE_C;
                    end else begin
                        w_state_nx  = WAITSELECTION;
                        w_credit_nx = 8'd0;
                    end
                end else begin
                    w_pulse_nx = r_pulse + PW'(1);
                end
            end
            CHANGERETURN: begin
                if (w_pulse_done) begin
                    w_state_nx  = WAITSELECTION;
                    w_credit_nx = 8'd0;
                    w_change_nx = 8'd0;
                    w_pulse_nx  = '0;
                end else begin
                    w_pulse_nx = r_pulse + PW'(1);
                end
            end
            default: begin
                w_state_nx  = WAITSELECTION;
                w_credit_nx = 8'd0;
                w_change_nx = 8'd0;
                w_pulse_nx  = '0;
                w_tmo_nx    = '0;
            end
        endcase
    end

    assign fsm_state  = r_state;
    assign credit     = r_credit;
    assign change_amt = r_change;
    assign busy       = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with PRICE=75, PULSE_CYCLES=4, TIMEOUT_CYCLES=8.
module tb_vend_sequencer;

    localparam logic [2:0] S_WSEL = 3'd0;
    localparam logic [2:0] S_WPAY = 3'd1;
    localparam logic [2:0] S_GOTQ = 3'd2;
    localparam logic [2:0] S_GOTD = 3'd3;
    localparam logic [2:0] S_DISP = 3'd4;
    localparam logic [2:0] S_CHG  = 3'd5;

    logic       clk;
    logic       rst_n;
    logic       select;
    logic       coin_quarter;
    logic       coin_dime;
    logic       cancel;
    logic [2:0] fsm_state;
    logic [7:0] credit;
    logic [7:0] change_amt;
    logic       busy;

    int n_cmp;
    int n_err;
    logic [7:0] exp_q[$];

    vend_sequencer #(
        .PRICE         (75),
        .PULSE_CYCLES  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .select      (select),
        .coin_quarter(coin_quarter),
        .coin_dime   (coin_dime),
        .cancel      (cancel),
        .fsm_state   (fsm_state),
        .credit      (credit),
        .change_amt  (change_amt),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs; returns #1 after the sampling edge
    task automatic step(input logic s, input logic q, input logic d, input logic c);
        select       = s;
        coin_quarter = q;
        coin_dime    = d;
        cancel       = c;
        @(posedge clk);
        #1;
        select       = 1'b0;
        coin_quarter = 1'b0;
        coin_dime    = 1'b0;
        cancel       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // cycles spent in 'code' starting from the current sample
    task automatic count_state(input logic [2:0] code, output int cnt);
        cnt = 0;
        while (fsm_state == code && cnt < 50) begin
            cnt++;
            idle(1);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"},  int'(fsm_state),  int'(S_WSEL));
        chk({tag, "_credit"}, int'(credit),     0);
        chk({tag, "_change"}, int'(change_amt), 0);
        chk({tag, "_busy"},   int'(busy),       0);
    endtask

    initial begin
        int cnt;
        int k;
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        select       = 1'b0;
        coin_quarter = 1'b0;
        coin_dime    = 1'b0;
        cancel       = 1'b0;

        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // exact pay: three quarters spaced 3 cycles apart
        exp_q.push_back(8'd25);
        exp_q.push_back(8'd50);
        exp_q.push_back(8'd75);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("exact_sel_state", int'(fsm_state), int'(S_WPAY));
        chk("exact_sel_busy",  int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            chk("exact_gotq_state", int'(fsm_state), int'(S_GOTQ));
            chk("exact_credit", int'(credit), int'(exp_q.pop_front()));
            if (i < 2) begin
                idle(2);
                chk("exact_wpay_state", int'(fsm_state), int'(S_WPAY));
            end
        end
        idle(1);
        count_state(S_DISP, cnt);
        chk("exact_disp_cycles", cnt, 4);
        chk_idle_outputs("exact_end");

        // overpay: q q d d d -> 80, change 5
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("over_credit60", int'(credit), 60);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("over_gotd_state", int'(fsm_state), int'(S_GOTD));
        chk("over_credit80", int'(credit), 80);
        idle(1);
        count_state(S_DISP, cnt);
        chk("over_disp_cycles", cnt, 4);
        chk("over_chg_state", int'(fsm_state), int'(S_CHG));
        chk("over_change", int'(change_amt), 5);
        count_state(S_CHG, cnt);
        chk("over_chg_cycles", cnt, 4);
        chk_idle_outputs("over_end");

        // cancel with credit 35
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("cancel_state", int'(fsm_state), int'(S_CHG));
        chk("cancel_change", int'(change_amt), 35);
        count_state(S_CHG, cnt);
        chk("cancel_chg_cycles", cnt, 4);
        chk_idle_outputs("cancel_end");
        // cancel at zero credit
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_idle_outputs("cancel0");

        // timeout: 8 edges after the dime
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tmo_credit", int'(credit), 10);
        k = 0;
        while (fsm_state != S_CHG && k < 20) begin
            idle(1);
            k++;
        end
        chk("tmo_edges", k, 8);
        chk("tmo_change", int'(change_amt), 10);
        count_state(S_CHG, cnt);
        chk("tmo_chg_cycles", cnt, 4);
        chk_idle_outputs("tmo_end");

        // collisions
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("coll_qd_state", int'(fsm_state), int'(S_GOTQ));
        chk("coll_qd_credit", int'(credit), 25);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("coll_dc_state", int'(fsm_state), int'(S_GOTD));
        chk("coll_dc_credit", int'(credit), 35);
        idle(1);
        chk("coll_dc_wpay", int'(fsm_state), int'(S_WPAY));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        count_state(S_CHG, cnt);
        chk("coll_chg_cycles", cnt, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk_idle_outputs("coll_idle_coins");

        // reset during 2nd DISPENSING cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            idle(1);
        end
        chk("rst_disp1", int'(fsm_state), int'(S_DISP));
        idle(1);
        chk("rst_disp2", int'(fsm_state), int'(S_DISP));
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rst_async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        chk_idle_outputs("rst_after");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_sel_state", int'(fsm_state), int'(S_WPAY));
        chk("rst_sel_credit", int'(credit), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
